// File: rtl/axi3_rd_arbiter.sv
// Round-robin arbiter sharing one AXI3 read channel among N_MASTER refill engines.
// One burst in flight: the granted master's AR is forwarded, then its R beats until RLAST.
module axi3_rd_arbiter #(
  parameter int N_MASTER   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_MASTER-1:0]            m_arvalid,
  input  logic [N_MASTER*ADDR_WIDTH-1:0] m_araddr,
  input  logic [N_MASTER*4-1:0]          m_arlen,
  input  logic [N_MASTER*3-1:0]          m_arsize,
  input  logic [N_MASTER*2-1:0]          m_arburst,
  output logic [N_MASTER-1:0]            m_arready,
  output logic [N_MASTER-1:0]            m_rvalid,
  input  logic [N_MASTER-1:0]            m_rready,
  output logic [DATA_WIDTH-1:0]          m_rdata,
  output logic [1:0]                     m_rresp,
  output logic                           m_rlast,
  output logic                           s_arvalid,
  input  logic                           s_arready,
  output logic [ADDR_WIDTH-1:0]          s_araddr,
  output logic [3:0]                     s_arlen,
  output logic [2:0]                     s_arsize,
  output logic [1:0]                     s_arburst,
  output logic [ID_WIDTH-1:0]            s_arid,
  input  logic                           s_rvalid,
  output logic                           s_rready,
  input  logic [DATA_WIDTH-1:0]          s_rdata,
  input  logic [1:0]                     s_rresp,
  input  logic                           s_rlast,
  input  logic [ID_WIDTH-1:0]            s_rid
);

  localparam int GW = $clog2(N_MASTER);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] grant, grant_nxt;
  logic [GW-1:0] last_grant, last_grant_nxt;
  logic [GW-1:0] pick;
  logic [GW-1:0] idx;
  logic          found;
  logic [31:0]   gidx;
  logic          rid_unused;

  // Only one burst is ever outstanding, so the returned ID carries no routing information.
  assign rid_unused = ^s_rid;

  assign gidx      = 32'(grant);
  assign s_araddr  = m_araddr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_arlen   = m_arlen[gidx*4 +: 4];
  assign s_arsize  = m_arsize[gidx*3 +: 3];
  assign s_arburst = m_arburst[gidx*2 +: 2];
  assign s_arid    = ID_WIDTH'(grant);
  assign m_rdata   = s_rdata;
  assign m_rresp   = s_rresp;
  assign m_rlast   = s_rlast;

  // Scan upward starting just past the last served master so it ranks lowest.
  always_comb begin
    pick  = grant;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_MASTER; i++) begin
      idx = GW'((32'(last_grant) + 32'(i)) % 32'(N_MASTER));
      if (!found && m_arvalid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(N_MASTER - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    s_arvalid      = 1'b0;
    s_rready       = 1'b0;
    m_arready      = '0;
    m_rvalid       = '0;
    unique case (state)
      IDLE: begin
        if (|m_arvalid) begin
          grant_nxt = pick;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        s_arvalid        = m_arvalid[grant];
        m_arready[grant] = s_arready;
        // A master withdrawing its request mid-address phase is tolerated: nothing is issued.
        if (!m_arvalid[grant]) begin
          state_nxt = IDLE;
        end else if (s_arready) begin
          last_grant_nxt = grant;
          state_nxt      = DATA;
        end
      end
      DATA: begin
        m_rvalid[grant] = s_rvalid;
        s_rready        = m_rready[grant];
        if (s_rvalid && s_rready && s_rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// Directed bench for axi3_rd_arbiter: a memory-like slave model answers AR requests and a
// scoreboard queue holds the R beats each master should receive, in order.
module tb_axi3_rd_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  typedef struct packed {
    logic          m;
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic          l;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
  logic [N*AW-1:0] m_araddr;
  logic [N*4-1:0]  m_arlen;
  logic [N*3-1:0]  m_arsize;
  logic [N*2-1:0]  m_arburst;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rlast;
  logic            s_arvalid, s_arready;
  logic [AW-1:0]   s_araddr;
  logic [3:0]      s_arlen;
  logic [2:0]      s_arsize;
  logic [1:0]      s_arburst;
  logic [IW-1:0]   s_arid;
  logic            s_rvalid, s_rready;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rlast;
  logic [IW-1:0]   s_rid;

  int    vectors     = 0;
  int    miscompares = 0;
  int    cyc         = 0;
  int    rlast_edge  = -1;
  beat_t q[$];

  axi3_rd_arbiter #(.N_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arid(s_arid),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  // Slave model: accepts one burst, streams incrementing-address beats, resets with the arbiter.
  logic          sl_busy;
  logic [AW-1:0] sl_base;
  logic [3:0]    sl_len, sl_beat;
  logic [IW-1:0] sl_id;

  always @(posedge clk) begin
    if (rst) begin
      sl_busy <= 1'b0;
      sl_beat <= '0;
    end else if (!sl_busy && s_arvalid && s_arready) begin
      sl_busy <= 1'b1;
      sl_base <= s_araddr;
      sl_len  <= s_arlen;
      sl_id   <= s_arid;
      sl_beat <= '0;
    end else if (sl_busy && s_rvalid && s_rready) begin
      sl_beat <= sl_beat + 4'd1;
      if (sl_beat == sl_len) sl_busy <= 1'b0;
    end
  end

  assign s_rvalid = sl_busy;
  assign s_rdata  = mem(sl_base + {26'd0, sl_beat, 2'b00});
  assign s_rresp  = sl_beat[1:0];
  assign s_rlast  = sl_busy && (sl_beat == sl_len);
  assign s_rid    = sl_id;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each R handshake is popped against the scoreboard.
  always @(negedge clk) begin
    beat_t got, exp;
    if (!rst) begin
      check("rvalid_onehot0", 64'($onehot0(m_rvalid)), 64'd1);
      for (int i = 0; i < N; i++) begin
        if (m_rvalid[i] && m_rready[i]) begin
          got.m = 1'(i);
          got.d = m_rdata;
          got.r = m_rresp;
          got.l = m_rlast;
          vectors++;
          assert (q.size() != 0) else begin
            miscompares++;
            $error("FAIL unexpected_beat observed=%0h expected=none", got);
          end
          if (q.size() != 0) begin
            exp = q.pop_front();
            check("rbeat", 64'(got), 64'(exp));
            if (m_rlast) rlast_edge = cyc + 1;
          end
        end
      end
    end
  end

  task automatic push_burst(input int m, input logic [AW-1:0] addr, input int len);
    beat_t b;
    for (int k = 0; k <= len; k++) begin
      b.m = 1'(m);
      b.d = mem(addr + 32'(4 * k));
      b.r = 2'(k);
      b.l = (k == len);
      q.push_back(b);
    end
  endtask

  task automatic req(input int m, input logic [AW-1:0] addr, input int len);
    m_araddr[m*AW +: AW] = addr;
    m_arlen[m*4 +: 4]    = 4'(len);
    m_arvalid[m]         = 1'b1;
    push_burst(m, addr, len);
  endtask

  // Enters at posedge+1, returns at posedge+1 just after the AR handshake edge.
  task automatic wait_hs(input string tag, input int id, output int hs_edge);
    int n = 0;
    #1;
    while (!(s_arvalid && s_arready) && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    check({tag, "_timeout"}, 64'(n < 60), 64'd1);
    check({tag, "_arid"}, 64'(s_arid), 64'(id));
    check({tag, "_arready"}, 64'(m_arready), 64'(1 << id));
    hs_edge = cyc + 1;
    @(posedge clk); #1;
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    #1;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    check({tag, "_timeout"}, 64'(n < 100), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "simulation hung");
  end

  initial begin
    int e, n;
    m_arvalid = '0;
    m_araddr  = '0;
    m_arlen   = '0;
    m_arsize  = {3'd1, 3'd2};
    m_arburst = {2'b10, 2'b01};
    m_rready  = '1;
    s_arready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_arready", 64'(m_arready), 64'd0);
    check("rst_s_arvalid", 64'(s_arvalid), 64'd0);
    check("rst_rvalid", 64'(m_rvalid), 64'd0);
    check("rst_s_rready", 64'(s_rready), 64'd0);

    // Single master, 8-beat burst.
    req(0, 32'h100, 7);
    #1;
    check("t1_arb_latency", 64'(s_arvalid), 64'd0);
    @(posedge clk); #1;
    check("t1_s_arvalid", 64'(s_arvalid), 64'd1);
    check("t1_s_araddr", 64'(s_araddr), 64'h100);
    check("t1_s_arlen", 64'(s_arlen), 64'd7);
    wait_hs("t1", 0, e);
    m_arvalid[0] = 1'b0;
    wait_empty("t1_done");
    check("t1_idle_rvalid", 64'(m_rvalid), 64'd0);
    check("t1_idle_s_rready", 64'(s_rready), 64'd0);
    check("t1_idle_s_arvalid", 64'(s_arvalid), 64'd0);

    // Both request together after reset, then keep requesting: grants 0,1,0,1,0,1.
    rst_pulse();
    req(0, 32'h200, 1);
    req(1, 32'h300, 2);
    for (int r = 0; r < 2; r++) begin
      push_burst(0, 32'h200, 1);
      push_burst(1, 32'h300, 2);
    end
    for (int r = 0; r < 6; r++) begin
      wait_hs($sformatf("t2_round%0d", r), r % 2, e);
    end
    m_arvalid = '0;
    wait_empty("t2_done");

    // A request arriving during another master's data phase waits for RLAST + 2 cycles.
    req(0, 32'h400, 3);
    wait_hs("t3_m0", 0, e);
    m_arvalid[0] = 1'b0;
    req(1, 32'h500, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_m1_blocked", 64'(m_arready[1]), 64'd0);
      @(posedge clk); #1;
    end
    wait_hs("t3_m1", 1, e);
    m_arvalid[1] = 1'b0;
    check("t3_rlast_to_ar", 64'(e - rlast_edge), 64'd2);
    wait_empty("t3_done");

    // Master back-pressure mid-burst reaches the slave.
    req(0, 32'h600, 3);
    wait_hs("t4", 0, e);
    m_arvalid[0] = 1'b0;
    @(posedge clk); #1;
    m_rready[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_s_rready", 64'(s_rready), 64'd0);
      check("t4_rvalid_held", 64'(m_rvalid), 64'd1);
      @(posedge clk); #1;
    end
    m_rready[0] = 1'b1;
    wait_empty("t4_done");

    // Reset in the middle of an 8-beat burst.
    req(0, 32'h700, 7);
    wait_hs("t5", 0, e);
    m_arvalid[0] = 1'b0;
    n = 0;
    #1;
    while (q.size() > 5 && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    check("t5_beats_before_rst", 64'(q.size()), 64'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    #1;
    check("t5_rvalid", 64'(m_rvalid), 64'd0);
    check("t5_s_rready", 64'(s_rready), 64'd0);
    check("t5_s_arvalid", 64'(s_arvalid), 64'd0);
    check("t5_arready", 64'(m_arready), 64'd0);
    req(1, 32'h800, 2);
    wait_hs("t5_m1", 1, e);
    m_arvalid[1] = 1'b0;
    wait_empty("t5_done");

    // Slave stalls AR for 5 cycles.
    s_arready = 1'b0;
    req(0, 32'h900, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      check("t6_s_arvalid", 64'(s_arvalid), 64'd1);
      check("t6_s_araddr", 64'(s_araddr), 64'h900);
      check("t6_s_arid", 64'(s_arid), 64'd0);
      check("t6_s_arsize", 64'(s_arsize), 64'd2);
      check("t6_s_arburst", 64'(s_arburst), 64'd1);
      check("t6_arready", 64'(m_arready), 64'd0);
      @(posedge clk); #1;
    end
    s_arready = 1'b1;
    wait_hs("t6", 0, e);
    m_arvalid[0] = 1'b0;
    wait_empty("t6_done");

    // Request withdrawn during the address phase: nothing is issued.
    s_arready = 1'b0;
    m_araddr[AW +: AW] = 32'hA00;
    m_arvalid[1] = 1'b1;
    @(posedge clk); #1;
    check("t7_s_arvalid", 64'(s_arvalid), 64'd1);
    check("t7_s_arid", 64'(s_arid), 64'd1);
    check("t7_s_arsize", 64'(s_arsize), 64'd1);
    m_arvalid[1] = 1'b0;
    #1;
    check("t7_withdrawn", 64'(s_arvalid), 64'd0);
    @(posedge clk); #1;
    s_arready = 1'b1;
    check("t7_idle_s_arvalid", 64'(s_arvalid), 64'd0);
    check("t7_idle_arready", 64'(m_arready), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check("t7_no_data", 64'(m_rvalid), 64'd0);
    check("final_queue_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
